// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: mode/state encodings and per-mode seed table.
// SEQ_GEN_SYLV_EN selects whether mode 7 gets a real seed.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      M_SQUARE  = 3'd0,
      M_POW3    = 3'd1,
      M_TRI     = 3'd2,
      M_FIB     = 3'd3,
      M_PELL    = 3'd4,
      M_LUCAS   = 3'd5,
      M_PADOVAN = 3'd6,
      M_SYLV    = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_IDLE = 2'd1,
      S_RUN  = 2'd2
   } state_e;

   // Seeds are tiny, so they are stored width-independent and
   // zero-extended by the user.
   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] c;
   } seed_t;

   localparam seed_t SEED_ZERO  = '{a: 2'd0, b: 2'd0, c: 2'd0};
   localparam seed_t SEED_ONE   = '{a: 2'd1, b: 2'd0, c: 2'd0};
   localparam seed_t SEED_FIB   = '{a: 2'd1, b: 2'd1, c: 2'd0};
   localparam seed_t SEED_PELL  = '{a: 2'd0, b: 2'd1, c: 2'd0};
   localparam seed_t SEED_LUCAS = '{a: 2'd2, b: 2'd1, c: 2'd0};
   localparam seed_t SEED_PADO  = '{a: 2'd1, b: 2'd1, c: 2'd1};
`ifdef SEQ_GEN_SYLV_EN
   localparam seed_t SEED_SYLV  = '{a: 2'd2, b: 2'd0, c: 2'd0};
`else
   localparam seed_t SEED_SYLV  = SEED_ZERO;
`endif

   function automatic seed_t seed_of(mode_e m);
      seed_t s;
      s = SEED_ZERO;
      unique case (m)
         M_SQUARE:  s = SEED_ZERO;
         M_POW3:    s = SEED_ONE;
         M_TRI:     s = SEED_ZERO;
         M_FIB:     s = SEED_FIB;
         M_PELL:    s = SEED_PELL;
         M_LUCAS:   s = SEED_LUCAS;
         M_PADOVAN: s = SEED_PADO;
         M_SYLV:    s = SEED_SYLV;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seq_gen_alu.sv
// seq_gen_alu: next-term recurrence for every mode plus carry-out.
// SEQ_GEN_SYLV_EN adds the mode 7 multiplier; otherwise mode 7 yields 0.
module seq_gen_alu
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_e            mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] idx,
   output logic [WIDTH-1:0] a_n,
   output logic [WIDTH-1:0] b_n,
   output logic [WIDTH-1:0] c_n,
   output logic             carry
);

   localparam int W2 = 2 * WIDTH;

   logic [WIDTH-1:0] n1;
   logic [W2-1:0]    sq;
   logic [WIDTH+1:0] sum;
`ifdef SEQ_GEN_SYLV_EN
   logic [WIDTH-1:0] am1;
   logic [W2-1:0]    prod;
`endif

   always_comb begin
      a_n   = a;
      b_n   = b;
      c_n   = c;
      carry = 1'b0;
      n1    = idx + WIDTH'(1);
      sq    = {{WIDTH{1'b0}}, n1} * {{WIDTH{1'b0}}, n1};
      sum   = '0;
`ifdef SEQ_GEN_SYLV_EN
      am1   = a - WIDTH'(1);
      prod  = ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, am1})
            + W2'(1);
`endif
      unique case (mode)
         M_SQUARE: begin
            a_n   = sq[WIDTH-1:0];
            carry = |sq[W2-1:WIDTH];
         end
         M_POW3: begin
            sum   = {1'b0, a, 1'b0} + {2'b00, a};
            a_n   = sum[WIDTH-1:0];
            carry = |sum[WIDTH+1:WIDTH];
         end
         M_TRI: begin
            sum   = {2'b00, a} + {2'b00, idx}
                  + (WIDTH+2)'(1);
            a_n   = sum[WIDTH-1:0];
            carry = |sum[WIDTH+1:WIDTH];
         end
         M_FIB, M_LUCAS: begin
            sum   = {2'b00, a} + {2'b00, b};
            a_n   = b;
            b_n   = sum[WIDTH-1:0];
            carry = |sum[WIDTH+1:WIDTH];
         end
         M_PELL: begin
            sum   = {2'b00, a} + {1'b0, b, 1'b0};
            a_n   = b;
            b_n   = sum[WIDTH-1:0];
            carry = |sum[WIDTH+1:WIDTH];
         end
         M_PADOVAN: begin
            sum   = {2'b00, a} + {2'b00, b};
            a_n   = b;
            b_n   = c;
            c_n   = sum[WIDTH-1:0];
            carry = |sum[WIDTH+1:WIDTH];
         end
         M_SYLV: begin
`ifdef SEQ_GEN_SYLV_EN
            a_n   = prod[WIDTH-1:0];
            carry = |prod[W2-1:WIDTH];
`else
            a_n   = '0;
`endif
         end
      endcase
   end

endmodule

// File: rtl/seq_gen_bank.sv
// seq_gen_bank: mode-selected integer sequence engine with LOAD/IDLE/RUN FSM.
// Define SEQ_GEN_SYLV_EN to enable the Sylvester (mode 7) multiplier.
module seq_gen_bank
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic             run,
   input  logic             step,
   input  logic             clear,
   output logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] index,
   output logic             term_valid,
   output logic             ovf,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic [2:0]       mode_q;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [WIDTH-1:0] idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] a_n, b_n, c_n;
   logic             carry;
   logic             adv;
   seed_t            seed;

   seq_gen_alu #(.WIDTH(WIDTH)) u_alu (
      .mode  (mode_e'(mode_q)),
      .a     (a_q),
      .b     (b_q),
      .c     (c_q),
      .idx   (idx_q),
      .a_n   (a_n),
      .b_n   (b_n),
      .c_n   (c_n),
      .carry (carry)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      vld_d   = 1'b0;
      adv     = 1'b0;
      seed    = seed_of(mode_e'(mode_q));
      if (clear || (mode != mode_q)) begin
         state_d = S_LOAD;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               state_d = S_IDLE;
               a_d     = WIDTH'(seed.a);
               b_d     = WIDTH'(seed.b);
               c_d     = WIDTH'(seed.c);
               idx_d   = '0;
               ovf_d   = 1'b0;
               vld_d   = 1'b1;
            end
            S_IDLE: begin
               // run wins over step; both together give a single advance
               if (run) state_d = S_RUN;
               adv = run || step;
            end
            S_RUN: begin
               if (run) adv = 1'b1;
               else     state_d = S_IDLE;
            end
            default: state_d = S_LOAD;
         endcase
      end
      if (adv) begin
         a_d   = a_n;
         b_d   = b_n;
         c_d   = c_n;
         idx_d = idx_q + WIDTH'(1);
         ovf_d = ovf_q | carry;
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOAD;
         mode_q  <= mode;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         ovf_q   <= ovf_d;
      end
   end

   assign term       = a_q;
   assign index      = idx_q;
   assign term_valid = vld_q;
   assign ovf        = ovf_q;
   assign state      = state_q;

endmodule

// File: tb/tb_seq_gen_bank.sv
// tb_seq_gen_bank: directed vectors for seq_gen_bank at WIDTH=8.
// Mode 7 expectations follow SEQ_GEN_SYLV_EN.
module tb_seq_gen_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic       run, step, clear;
   logic [7:0] term, index;
   logic       term_valid, ovf;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;
   int ev[$];

   seq_gen_bank #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .run        (run),
      .step       (step),
      .clear      (clear),
      .term       (term),
      .index      (index),
      .term_valid (term_valid),
      .ovf        (ovf),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (index %0d)",
                  tag, got, exp, index);
      end
   endtask

   task automatic seq_chk(input int ovf_at);
      foreach (ev[i]) begin
         tick();
         chk("term", term, ev[i]);
         chk("index", index, i);
         chk("valid", term_valid, 1);
         chk("ovf", ovf, (ovf_at >= 0 && i >= ovf_at) ? 1 : 0);
      end
   endtask

   task automatic run_mode(input logic [2:0] m, input int ovf_at);
      mode = m;
      run  = 1'b1;
      tick();
      chk("chg_state", state, 0);
      chk("chg_valid", term_valid, 0);
      seq_chk(ovf_at);
   endtask

   initial begin
      reset = 1'b1;
      mode  = 3'd3;
      run   = 1'b1;
      step  = 1'b0;
      clear = 1'b0;
      tick();
      tick();
      chk("rst_term", term, 0);
      chk("rst_index", index, 0);
      chk("rst_valid", term_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_state", state, 0);

      // Fibonacci free-run straight out of reset
      reset = 1'b0;
      ev = '{1, 1, 2, 3, 5, 8, 13};
      seq_chk(-1);
      chk("fib_state", state, 2);

      // clear, rerun Fibonacci to 8, then switch to Lucas
      clear = 1'b1;
      tick();
      chk("clr_state", state, 0);
      chk("clr_valid", term_valid, 0);
      clear = 1'b0;
      ev = '{1, 1, 2, 3, 5, 8};
      seq_chk(-1);
      ev = '{2, 1, 3, 4, 7};
      run_mode(3'd5, -1);

      // powers of 3 overflow, sticky until clear
      ev = '{1, 3, 9, 27, 81, 243, 217, 139};
      run_mode(3'd1, 6);
      run = 1'b0;
      tick();
      chk("stop_state", state, 1);
      chk("stop_term", term, 139);
      chk("stop_valid", term_valid, 0);
      chk("stop_ovf", ovf, 1);
      clear = 1'b1;
      tick();
      chk("clr_ovf_hold", ovf, 1);
      chk("clr_state2", state, 0);
      clear = 1'b0;
      tick();
      chk("clr_ovf", ovf, 0);
      chk("clr_term", term, 1);
      chk("clr_state3", state, 1);

      // Padovan single-stepping
      mode = 3'd6;
      tick();
      chk("pad_load", state, 0);
      tick();
      chk("pad_seed", term, 1);
      chk("pad_state", state, 1);
      ev = '{1, 1, 2, 2, 3, 4};
      foreach (ev[i]) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         chk("step_term", term, ev[i]);
         chk("step_index", index, i + 1);
         chk("step_valid", term_valid, 1);
         chk("step_state", state, 1);
         tick();
         chk("gap_valid", term_valid, 0);
         chk("gap_term", term, ev[i]);
      end
      run  = 1'b1;
      step = 1'b1;
      tick();
      chk("rs_term", term, 5);
      chk("rs_index", index, 7);
      chk("rs_state", state, 2);
      run  = 1'b0;
      step = 1'b0;
      tick();
      chk("rs_hold", term, 5);
      chk("rs_idle", state, 1);
      chk("rs_valid", term_valid, 0);

      // squares with overflow at index 16
      ev.delete();
      for (int i = 0; i <= 16; i++) ev.push_back((i * i) & 255);
      run_mode(3'd0, 16);

      ev = '{0, 1, 3, 6, 10, 15};
      run_mode(3'd2, -1);
      ev = '{0, 1, 2, 5, 12, 29};
      run_mode(3'd4, -1);

`ifdef SEQ_GEN_SYLV_EN
      ev = '{2, 3, 7, 43, 15};
      run_mode(3'd7, 4);
`else
      ev = '{0, 0, 0, 0, 0};
      run_mode(3'd7, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
